// File: rtl/mem_access_unit_pkg.sv
// Shared types, widths and data-formatting helpers for the memory access unit.
package mem_access_unit_pkg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = 3;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } mau_state_e;

   // Byte enables for an access of size sz starting at byte lane off
   function automatic logic [STRB_W-1:0] strobe_mask(msize_t sz, logic [OFF_W-1:0] off);
      logic [STRB_W-1:0] base;
      case (sz)
         MSIZE1:  base = 8'h01;
         MSIZE2:  base = 8'h03;
         MSIZE4:  base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

   // Sign- or zero-extend LSB-aligned load data from the access width
   function automatic logic [DATA_W-1:0] load_extend(logic [DATA_W-1:0] d, msize_t sz, logic uns);
      logic [DATA_W-1:0] r;
      case (sz)
         MSIZE1:  r = {{56{~uns & d[7]}},  d[7:0]};
         MSIZE2:  r = {{48{~uns & d[15]}}, d[15:0]};
         MSIZE4:  r = {{32{~uns & d[31]}}, d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/response bundle between the memory stage and the bus.
interface mem_access_unit_if;
   import mem_access_unit_pkg::*;

   logic              req_valid;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_size;
   logic [STRB_W-1:0] req_strobe;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_data_ok;
   logic [DATA_W-1:0] resp_data;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_strobe, req_wdata,
      input  resp_data_ok, resp_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_strobe, req_wdata,
      output resp_data_ok, resp_data
   );
endinterface

// File: rtl/mem_data_align.sv
// Combinational store lane shifting, strobe generation and load extraction/extension.
module mem_data_align
   import mem_access_unit_pkg::*;
(
   input  logic [OFF_W-1:0]  off_i,
   input  msize_t            size_i,
   input  logic              unsigned_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [STRB_W-1:0] strobe_o,
   output logic [DATA_W-1:0] ldata_o
);

   logic [5:0] bit_sh;

   // Byte offset expressed as a bit shift
   assign bit_sh   = {off_i, 3'b000};
   assign wdata_o  = wdata_i << bit_sh;
   assign strobe_o = strobe_mask(size_i, off_i);
   assign ldata_o  = load_extend(rdata_i >> bit_sh, size_i, unsigned_i);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage data-bus initiator: issues loads/stores, formats results, raises Dwait.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses are not issued and
// instead report out_misalign with the faulting address as the result.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_new,
   input  logic              in_load,
   input  logic              in_store,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [DATA_W-1:0] in_alu_result,
   mem_access_unit_if.master bus,
   output logic [DATA_W-1:0] out_result,
   output logic              Dwait,
   output logic              out_misalign
);

   mau_state_e        state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_mis_q, hold_mis_d;

   msize_t            size_c;
   logic              mem_op_c;
   logic              trap_c;
   logic [DATA_W-1:0] ldata_c;
   logic [DATA_W-1:0] fmt_c;
   logic [STRB_W-1:0] strobe_c;
   logic [DATA_W-1:0] wdata_sh_c;
   logic              req_valid_c;
   logic              dwait_c;
   logic [DATA_W-1:0] result_c;
   logic              misalign_c;

   assign size_c   = msize_t'(in_size);
   assign mem_op_c = in_valid & (in_load | in_store);
   assign fmt_c    = in_load ? ldata_c : in_alu_result;

   mem_data_align u_align (
      .off_i      (in_addr[OFF_W-1:0]),
      .size_i     (size_c),
      .unsigned_i (in_unsigned),
      .wdata_i    (in_wdata),
      .rdata_i    (bus.resp_data),
      .wdata_o    (wdata_sh_c),
      .strobe_o   (strobe_c),
      .ldata_o    (ldata_c)
   );

`ifdef MISALIGN_TRAP_EN
   // Natural-alignment check for the access size
   always_comb begin
      case (size_c)
         MSIZE1:  trap_c = 1'b0;
         MSIZE2:  trap_c = mem_op_c & in_addr[0];
         MSIZE4:  trap_c = mem_op_c & (|in_addr[1:0]);
         default: trap_c = mem_op_c & (|in_addr[2:0]);
      endcase
   end
`else
   assign trap_c = 1'b0;
`endif

   // Request payload follows the frozen M-stage inputs directly
   assign bus.req_write  = in_store & ~in_load;
   assign bus.req_addr   = in_addr;
   assign bus.req_size   = {1'b0, in_size};
   assign bus.req_strobe = in_load ? '0 : strobe_c;
   assign bus.req_wdata  = wdata_sh_c;

   // State and captured-result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         hold_mis_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         hold_mis_q <= hold_mis_d;
      end
   end

   // Next state, request/stall control and result selection
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_mis_d  = hold_mis_q;
      req_valid_c = 1'b0;
      dwait_c     = 1'b0;
      result_c    = hold_q;
      misalign_c  = hold_mis_q;

      case (state_q)
         BUSY: begin
            req_valid_c = 1'b1;
            dwait_c     = ~bus.resp_data_ok;
            result_c    = fmt_c;
            misalign_c  = 1'b0;
            if (bus.resp_data_ok) begin
               hold_d     = fmt_c;
               hold_mis_d = 1'b0;
               state_d    = HOLD;
            end
         end
         default: begin
            // IDLE always evaluates; HOLD only once a new instruction arrives
            if (state_q == IDLE || in_new) begin
               misalign_c = 1'b0;
               if (!mem_op_c) begin
                  result_c = in_alu_result;
                  state_d  = IDLE;
               end else if (trap_c) begin
                  result_c   = DATA_W'(in_addr);
                  misalign_c = 1'b1;
                  hold_d     = DATA_W'(in_addr);
                  hold_mis_d = 1'b1;
                  state_d    = HOLD;
               end else begin
                  req_valid_c = 1'b1;
                  result_c    = fmt_c;
                  if (bus.resp_data_ok) begin
                     hold_d     = fmt_c;
                     hold_mis_d = 1'b0;
                     state_d    = HOLD;
                  end else begin
                     dwait_c = 1'b1;
                     state_d = BUSY;
                  end
               end
            end
         end
      endcase

      // Outputs read as their reset values while reset is held
      if (reset) begin
         req_valid_c = 1'b0;
         dwait_c     = 1'b0;
         result_c    = '0;
         misalign_c  = 1'b0;
      end
   end

   assign bus.req_valid = req_valid_c;
   assign Dwait         = dwait_c;
   assign out_result    = result_c;
   assign out_misalign  = misalign_c;

   // The pipeline is stalled while an access is outstanding, so no new instruction may arrive
   a_no_new_in_busy: assert property (@(posedge clk) disable iff (reset)
      (state_q == BUSY) |-> !in_new);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed vectors plus randomized instruction stream.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_new, in_load, in_store, in_unsigned;
   logic [1:0]  in_size;
   logic [63:0] in_addr, in_wdata, in_alu_result;
   logic [63:0] out_result;
   logic        Dwait, out_misalign;

   mem_access_unit_if bus_if();

   mem_access_unit dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_new        (in_new),
      .in_load       (in_load),
      .in_store      (in_store),
      .in_size       (in_size),
      .in_unsigned   (in_unsigned),
      .in_addr       (in_addr),
      .in_wdata      (in_wdata),
      .in_alu_result (in_alu_result),
      .bus           (bus_if),
      .out_result    (out_result),
      .Dwait         (Dwait),
      .out_misalign  (out_misalign)
   );

   always #5 clk = ~clk;

   // kind: 0 = non-memory, 1 = memory access, 2 = frozen pipeline cycle
   typedef struct {
      int          kind;
      logic [63:0] res;
      logic        wr;
      logic [63:0] addr;
      logic [2:0]  sz;
      logic [7:0]  strb;
      logic [63:0] wd;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   bit          cur_mem = 1'b0;
   int          wait_left = 0;
   logic [63:0] cur_rdata = '0;
   logic [63:0] last_res = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Reference formatting: byte-by-byte from the access rules
   function automatic logic [7:0] model_strobe(input logic [1:0] sz, input logic [2:0] off);
      logic [7:0] s = '0;
      int nb = 1 << sz;
      for (int i = 0; i < 8; i++)
         if (i >= int'(off) && i < int'(off) + nb) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [2:0] off);
      logic [63:0] w = '0;
      for (int i = 0; i < 8; i++)
         if (i >= int'(off)) w[8*i +: 8] = wd[8*(i - int'(off)) +: 8];
      return w;
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [1:0] sz,
                                              input logic uns, input logic [2:0] off);
      logic [63:0] v = '0;
      int nb = 1 << sz;
      for (int k = 0; k < nb; k++)
         if (int'(off) + k < 8) v[8*k +: 8] = rd[8*(int'(off) + k) +: 8];
      if (!uns && nb < 8 && v[8*nb - 1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
      return v;
   endfunction

   // Monitor: pops one expectation per completed cycle (Dwait low)
   initial begin : monitor
      int   stall;
      exp_t e;
      stall = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            stall = 0;
         end else if (sb.size() != 0) begin
            e = sb[0];
            if (e.kind == 1) begin
               chk("req_valid", 64'(bus_if.req_valid), 64'd1);
               chk("req_addr", bus_if.req_addr, e.addr);
               chk("req_write_size", 64'({bus_if.req_write, bus_if.req_size}), 64'({e.wr, e.sz}));
               chk("req_strobe", 64'(bus_if.req_strobe), 64'(e.strb));
               if (e.wr) chk("req_wdata", bus_if.req_wdata, e.wd);
               if (Dwait) begin
                  stall++;
               end else begin
                  chk("mem_result", out_result, e.res);
                  chk("stall_cycles", 64'(stall), 64'(e.lat));
                  chk("misalign", 64'(out_misalign), 64'd0);
                  void'(sb.pop_front());
                  stall = 0;
               end
            end else begin
               chk(e.kind == 2 ? "hold_req_valid" : "alu_req_valid", 64'(bus_if.req_valid), 64'd0);
               chk(e.kind == 2 ? "hold_Dwait" : "alu_Dwait", 64'(Dwait), 64'd0);
               chk(e.kind == 2 ? "hold_result" : "alu_result", out_result, e.res);
               chk("misalign", 64'(out_misalign), 64'd0);
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic recover();
      mon_en = 1'b0;
      sb.delete();
      reset = 1'b1;
      in_valid = 1'b0; in_new = 1'b0; in_alu_result = '0;
      cur_mem = 1'b0;
      bus_if.resp_data_ok = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      last_res = '0;
      mon_en = 1'b1;
   endtask

   // Advance cycles, playing the bus slave, until the current expectation is consumed
   task automatic wait_drain();
      int guard = 0;
      forever begin
         @(posedge clk); #1;
         if (sb.size() == 0) return;
         in_new = 1'b0;
         if (cur_mem) begin
            if (wait_left > 0) wait_left--;
            bus_if.resp_data_ok = (wait_left == 0);
            bus_if.resp_data = (wait_left == 0) ? cur_rdata : {$urandom, $urandom};
         end
         guard++;
         if (guard > 40) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout at %0t: got Dwait=%0b expected completion within 40 cycles", $time, Dwait);
            recover();
            return;
         end
      end
   endtask

   task automatic issue(input logic v, ld, st, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, wd, alu, rd, input int lat);
      exp_t e;
      in_valid = v; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
      in_addr = addr; in_wdata = wd; in_alu_result = alu; in_new = 1'b1;
      cur_mem = v & (ld | st);
      cur_rdata = rd;
      wait_left = lat;
      if (cur_mem) begin
         bus_if.resp_data_ok = (lat == 0);
         bus_if.resp_data = (lat == 0) ? rd : {$urandom, $urandom};
      end else begin
         bus_if.resp_data_ok = 1'b0;
         bus_if.resp_data = {$urandom, $urandom};
      end
      e.kind = cur_mem ? 1 : 0;
      e.res  = (cur_mem && ld) ? model_load(rd, sz, uns, addr[2:0]) : alu;
      e.wr   = st;
      e.addr = addr;
      e.sz   = {1'b0, sz};
      e.strb = ld ? 8'h00 : model_strobe(sz, addr[2:0]);
      e.wd   = model_wdata(wd, addr[2:0]);
      e.lat  = lat;
      last_res = e.res;
      sb.push_back(e);
   endtask

   task automatic freeze();
      exp_t e;
      in_new = 1'b0;
      cur_mem = 1'b0;
      bus_if.resp_data_ok = 1'b0;
      e = '{kind: 2, res: last_res, wr: 1'b0, addr: '0, sz: '0, strb: '0, wd: '0, lat: 0};
      sb.push_back(e);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog at %0t: got no finish expected finish before 1ms", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int          r, lat;
      logic        v, ld, st, uns;
      logic [1:0]  sz;

      // Reset with a zero-latency load presented: outputs must still read idle
      reset = 1'b1;
      in_valid = 1'b1; in_new = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd3;
      in_unsigned = 1'b0; in_addr = 64'h10; in_wdata = '0; in_alu_result = 64'hDEAD;
      bus_if.resp_data_ok = 1'b1; bus_if.resp_data = 64'h1234;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", 64'(bus_if.req_valid), 64'd0);
      chk("rst_Dwait", 64'(Dwait), 64'd0);
      chk("rst_result", out_result, 64'd0);
      chk("rst_misalign", 64'(out_misalign), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_new = 1'b0; in_alu_result = '0;
      bus_if.resp_data_ok = 1'b0;
      mon_en = 1'b1;

      // Directed vectors
      wait_drain(); issue(1, 1, 0, 2'd2, 0, 64'h8000_0004, '0, 64'h77, 64'h8765_4321_0000_0000, 3);
      repeat (4) begin wait_drain(); freeze(); end
      wait_drain(); issue(1, 0, 0, 2'd3, 0, 64'h40, '0, 64'd5, '0, 0);
      wait_drain(); issue(1, 0, 1, 2'd0, 0, 64'h8000_0003, 64'hAB, 64'h99, '0, 1);
      wait_drain(); issue(1, 1, 0, 2'd0, 1, 64'h8000_0007, '0, 64'h11, 64'hF0 << 56, 0);
      repeat (2) begin wait_drain(); freeze(); end
      wait_drain(); issue(1, 0, 1, 2'd3, 0, 64'h8000_0002, 64'h1122_3344_5566_7788, 64'h3, '0, 2);

      // Reset while an access is outstanding
      wait_drain(); issue(1, 1, 0, 2'd3, 0, 64'h8000_0010, '0, '0, 64'h1234, 5);
      repeat (2) begin @(posedge clk); #1; in_new = 1'b0; end
      mon_en = 1'b0; sb.delete(); reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_alu_result = '0;
      cur_mem = 1'b0; bus_if.resp_data_ok = 1'b0;
      @(negedge clk);
      chk("busy_rst_req_valid", 64'(bus_if.req_valid), 64'd0);
      chk("busy_rst_Dwait", 64'(Dwait), 64'd0);
      chk("busy_rst_result", out_result, 64'd0);
      last_res = '0;
      mon_en = 1'b1;

      // Randomized instruction stream
      for (int n = 0; n < 400; n++) begin
         r   = $urandom_range(0, 9);
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         lat = $urandom_range(0, 4);
         wait_drain();
         if (r < 2) begin
            freeze();
         end else begin
            if (r < 4) begin
               v = 1'($urandom_range(0, 1));
               ld = v ? 1'b0 : 1'($urandom_range(0, 1));
               st = v ? 1'b0 : 1'($urandom_range(0, 1));
            end else if (r < 7) begin
               v = 1'b1; ld = 1'b1; st = 1'b0;
            end else begin
               v = 1'b1; ld = 1'b0; st = 1'b1;
            end
            issue(v, ld, st, sz, uns, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, lat);
         end
      end
      wait_drain();
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
